// File: rtl/armv8_register_file_pkg.sv
// ---------------------------------------------------------------------------
// armv8_register_file_pkg
// Shared constants and types for the ARMv8 general-purpose register file.
//   DATA_W   : register / data port width (64)
//   ADDR_W   : register index width (5)
//   NUM_REGS : architectural register count, equals 2**ADDR_W (32)
//   ZERO_IDX : index of the hard-wired zero register XZR (31)
// ---------------------------------------------------------------------------
package armv8_register_file_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int ZERO_IDX = 31;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  // True when the index addresses XZR.
  function automatic logic is_zero_idx(reg_idx_t idx);
    return idx == reg_idx_t'(ZERO_IDX);
  endfunction

endpackage

// File: rtl/armv8_register_file_if.sv
// ---------------------------------------------------------------------------
// armv8_register_file_if
// Read/write bus of the register file.
//   i_rn, i_rm     : read addresses for operand ports 0 and 1
//   o_reg0, o_reg1 : combinational read data for i_rn / i_rm
//   i_rd           : write address
//   i_dataWr       : write data
//   i_regWr        : write enable, active-high
// master drives addresses/write data; slave (the register file) drives reads.
// ---------------------------------------------------------------------------
interface armv8_register_file_if;
  import armv8_register_file_pkg::*;

  reg_idx_t  i_rn;
  reg_idx_t  i_rm;
  reg_data_t o_reg0;
  reg_data_t o_reg1;
  reg_idx_t  i_rd;
  reg_data_t i_dataWr;
  logic      i_regWr;

  modport master (
    output i_rn, i_rm, i_rd, i_dataWr, i_regWr,
    input  o_reg0, o_reg1
  );

  modport slave (
    input  i_rn, i_rm, i_rd, i_dataWr, i_regWr,
    output o_reg0, o_reg1
  );

endinterface

// File: rtl/armv8_register_file.sv
// ---------------------------------------------------------------------------
// armv8_register_file
// 32 x 64-bit ARMv8 general-purpose register file for the single-cycle
// datapath. Two zero-latency combinational read ports (Rn, Rm) and one
// rising-edge write port (Rd). Index 31 is XZR: it always reads zero and
// writes to it are dropped. No read-during-write forwarding: a read of the
// register being written shows the old value until the edge.
// Ports:
//   i_clk : clock, rising-edge active
//   i_rst : asynchronous active-high reset, clears every register
//   bus   : armv8_register_file_if.slave (read/write bus)
// ---------------------------------------------------------------------------
module armv8_register_file
  import armv8_register_file_pkg::*;
(
  input logic                  i_clk,
  input logic                  i_rst,
  armv8_register_file_if.slave bus
);

  reg_data_t regs [NUM_REGS];
  logic      wr_en;

  // Compare against 1'b1 so an X/Z enable evaluates as "no write".
  assign wr_en = (bus.i_regWr == 1'b1) && !is_zero_idx(bus.i_rd);

  // Write stage: reset has priority, so writes are blocked while it is held.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      regs <= '{default: '0};
    end else if (wr_en) begin
      regs[bus.i_rd] <= bus.i_dataWr;
    end
  end

  function automatic reg_data_t zero_masked_read(reg_idx_t idx);
    if (is_zero_idx(idx)) begin
      return '0;
    end
    return regs[idx];
  endfunction

  // Read stage: purely combinational, both ports share the same mask logic.
  always_comb begin
    bus.o_reg0 = zero_masked_read(bus.i_rn);
    bus.o_reg1 = zero_masked_read(bus.i_rm);
  end

endmodule

// File: tb/tb_armv8_register_file.sv
// ---------------------------------------------------------------------------
// tb_armv8_register_file
// Self-checking bench for armv8_register_file: directed multi-cycle
// sequences plus a table of read vectors, with expected read data queued
// when the read addresses are driven and popped when the outputs are sampled.
// ---------------------------------------------------------------------------
module tb_armv8_register_file;
  import armv8_register_file_pkg::*;

  localparam logic [63:0] STEP = 64'h0101_0101_0101_0101;

  typedef struct {
    reg_idx_t  rn;
    reg_idx_t  rm;
    reg_data_t exp0;
    reg_data_t exp1;
  } vec_t;

  typedef struct {
    string     name;
    reg_data_t exp0;
    reg_data_t exp1;
  } sb_t;

  logic i_clk;
  logic i_rst;
  int   tests_run;
  int   tests_failed;
  sb_t  sb_q [$];
  vec_t vecs [$];

  armv8_register_file_if bus ();

  armv8_register_file dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input reg_data_t act, input reg_data_t exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  // Drive read addresses and queue the expected data for them.
  task automatic drive_read(input string name, input reg_idx_t rn, input reg_idx_t rm,
                            input reg_data_t e0, input reg_data_t e1);
    sb_t s;
    bus.i_rn = rn;
    bus.i_rm = rm;
    s.name = name;
    s.exp0 = e0;
    s.exp1 = e1;
    sb_q.push_back(s);
  endtask

  // Pop the oldest expectation and compare both read ports against it.
  task automatic sample_read();
    sb_t s;
    if (sb_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard: empty queue on sample, got 0 entries expected 1");
      return;
    end
    s = sb_q.pop_front();
    check({s.name, ".reg0"}, bus.o_reg0, s.exp0);
    check({s.name, ".reg1"}, bus.o_reg1, s.exp1);
  endtask

  task automatic read_check(input string name, input reg_idx_t rn, input reg_idx_t rm,
                            input reg_data_t e0, input reg_data_t e1);
    @(negedge i_clk);
    drive_read(name, rn, rm, e0, e1);
    #1;
    sample_read();
  endtask

  task automatic write_reg(input reg_idx_t idx, input reg_data_t data);
    @(negedge i_clk);
    bus.i_rd     = idx;
    bus.i_dataWr = data;
    bus.i_regWr  = 1'b1;
    @(posedge i_clk);
    #1;
    bus.i_regWr  = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    // Read vector table: sweep pairs plus same-address and XZR reads.
    for (int k = 0; k <= 30; k++) begin
      vec_t v;
      v.rn   = reg_idx_t'(k);
      v.rm   = reg_idx_t'(30 - k);
      v.exp0 = 64'(k) * STEP;
      v.exp1 = 64'(30 - k) * STEP;
      vecs.push_back(v);
    end
    vecs.push_back('{rn: 5'd12, rm: 5'd12, exp0: 64'h0C0C_0C0C_0C0C_0C0C, exp1: 64'h0C0C_0C0C_0C0C_0C0C});
    vecs.push_back('{rn: 5'd31, rm: 5'd5,  exp0: 64'h0,                   exp1: 64'h0505_0505_0505_0505});
    vecs.push_back('{rn: 5'd30, rm: 5'd31, exp0: 64'h1E1E_1E1E_1E1E_1E1E, exp1: 64'h0});

    i_rst        = 1'b1;
    bus.i_rn     = '0;
    bus.i_rm     = '0;
    bus.i_rd     = '0;
    bus.i_dataWr = '0;
    bus.i_regWr  = 1'b0;

    // Reset state and writes blocked while reset is held.
    repeat (2) @(posedge i_clk);
    read_check("reset_x0_x1", 5'd0, 5'd1, 64'h0, 64'h0);
    @(negedge i_clk);
    bus.i_rd = 5'd4; bus.i_dataWr = 64'hCAFE; bus.i_regWr = 1'b1;
    @(posedge i_clk);
    #1 bus.i_regWr = 1'b0;
    read_check("reset_blocks_write", 5'd4, 5'd30, 64'h0, 64'h0);
    @(negedge i_clk);
    i_rst = 1'b0;
    read_check("after_reset_x4", 5'd4, 5'd4, 64'h0, 64'h0);

    // Basic write/read on both ports.
    write_reg(5'd0, 64'h1122_3344_5566_7788);
    write_reg(5'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    read_check("basic_rw", 5'd0, 5'd1, 64'h1122_3344_5566_7788, 64'hFFFF_FFFF_FFFF_FFFF);

    // Write enable off for three edges.
    @(negedge i_clk);
    bus.i_rd = 5'd3; bus.i_dataWr = 64'hABCD; bus.i_regWr = 1'b0;
    repeat (3) @(posedge i_clk);
    read_check("wr_disabled_x3", 5'd3, 5'd3, 64'h0, 64'h0);

    // XZR ignores writes and reads zero.
    write_reg(5'd31, 64'h1234);
    read_check("xzr", 5'd31, 5'd31, 64'h0, 64'h0);

    // Back-to-back writes: the last enabled edge wins.
    write_reg(5'd9, 64'h1111);
    write_reg(5'd9, 64'h2222);
    read_check("last_write_wins", 5'd9, 5'd0, 64'h2222, 64'h1122_3344_5566_7788);

    // Read-during-write: old value before the edge, new value after.
    write_reg(5'd7, 64'h10);
    @(negedge i_clk);
    drive_read("rdw_before", 5'd7, 5'd7, 64'h10, 64'h10);
    bus.i_rd = 5'd7; bus.i_dataWr = 64'h20; bus.i_regWr = 1'b1;
    #1 sample_read();
    @(posedge i_clk);
    drive_read("rdw_after", 5'd7, 5'd7, 64'h20, 64'h20);
    #1 sample_read();
    bus.i_regWr = 1'b0;

    // Asynchronous reset pulsed mid-cycle clears state with no clock edge.
    write_reg(5'd5, 64'hDEAD_BEEF_0000_0001);
    read_check("x5_written", 5'd5, 5'd7, 64'hDEAD_BEEF_0000_0001, 64'h20);
    @(negedge i_clk);
    #2 i_rst = 1'b1;
    drive_read("async_reset", 5'd5, 5'd7, 64'h0, 64'h0);
    #1 sample_read();
    #1 i_rst = 1'b0;
    read_check("post_async_reset", 5'd5, 5'd0, 64'h0, 64'h0);

    // Full sweep: fill X0..X30, then apply the vector table.
    for (int k = 0; k <= 30; k++) begin
      write_reg(reg_idx_t'(k), 64'(k) * STEP);
    end
    write_reg(5'd31, 64'hFFFF);
    foreach (vecs[i]) begin
      read_check($sformatf("vec%0d_rn%0d_rm%0d", i, vecs[i].rn, vecs[i].rm),
                 vecs[i].rn, vecs[i].rm, vecs[i].exp0, vecs[i].exp1);
    end

    if (sb_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
